// File: rtl/fwd_hazard_scoreboard.sv
// Hazard-detection and operand-forwarding scoreboard for the rv32 pipeline.
// Keeps a shadow record {valid, rd, is_load} for each post-decode stage,
// resolves rs1/rs2 from the youngest in-flight producer and requests a
// load-use stall while the matching load result is not yet on its stage bus.
module fwd_hazard_scoreboard #(
    parameter int unsigned  XLEN           = 32,
    parameter int unsigned  NSTAGE         = 3,
    parameter int unsigned  LOAD_RDY_STAGE = 1,
    parameter int unsigned  CNT_W          = 16,
    localparam int unsigned SEL_W          = $clog2(NSTAGE + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              instr_de,
    input  logic                     valid_de,
    input  logic                     hold,
    input  logic                     flush,
    input  logic [XLEN-1:0]          rs1_rf,
    input  logic [XLEN-1:0]          rs2_rf,
    input  logic [NSTAGE*XLEN-1:0]   stage_data,
    output logic [XLEN-1:0]          data_a_mgr,
    output logic [XLEN-1:0]          data_b_mgr,
    output logic [SEL_W-1:0]         fwd_sel_a,
    output logic [SEL_W-1:0]         fwd_sel_b,
    output logic                     stall,
    output logic [CNT_W-1:0]         stall_cnt
);

    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_LOAD   = 7'b0000011,
        OPC_OPIMM  = 7'b0010011,
        OPC_OP     = 7'b0110011,
        OPC_BRANCH = 7'b1100011,
        OPC_STORE  = 7'b0100011
    } opcode_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       is_load;
    } entry_t;

    typedef struct packed {
        logic [SEL_W-1:0] sel;
        logic [XLEN-1:0]  data;
        logic             late;
    } fwd_t;

    entry_t           shadow_q [NSTAGE];
    entry_t           shadow_d [NSTAGE];
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [4:0] rd_de, rs1_de, rs2_de;
    logic       writes_rd, is_load_de, uses_rs1, uses_rs2;
    fwd_t       fwd_a, fwd_b;
    logic       unused_funct;

    assign rd_de        = instr_de[11:7];
    assign rs1_de       = instr_de[19:15];
    assign rs2_de       = instr_de[24:20];
    assign unused_funct = ^{instr_de[31:25], instr_de[14:12]};

    // Opcode classification of the decode instruction.
    always_comb begin
        writes_rd  = 1'b0;
        is_load_de = 1'b0;
        uses_rs1   = 1'b0;
        uses_rs2   = 1'b0;
        case (instr_de[6:0])
            OPC_LUI, OPC_AUIPC, OPC_JAL: writes_rd = 1'b1;
            OPC_JALR, OPC_OPIMM: begin
                writes_rd = 1'b1;
                uses_rs1  = 1'b1;
            end
            OPC_LOAD: begin
                writes_rd  = 1'b1;
                is_load_de = 1'b1;
                uses_rs1   = 1'b1;
            end
            OPC_OP: begin
                writes_rd = 1'b1;
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
            end
            OPC_BRANCH, OPC_STORE: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            default: ;
        endcase
    end

    // Scan oldest to youngest so the youngest matching producer overwrites.
    function automatic fwd_t lookup(input logic use_src, input logic [4:0] rs,
                                    input logic [XLEN-1:0] rf);
        fwd_t        r;
        int unsigned s;
        r.sel  = '0;
        r.data = rf;
        r.late = 1'b0;
        if (use_src && rs != 5'd0) begin
            for (int unsigned i = 0; i < NSTAGE; i++) begin
                s = NSTAGE - 1 - i;
                if (shadow_q[s].valid && shadow_q[s].rd == rs) begin
                    r.sel  = SEL_W'(s + 1);
                    r.data = stage_data[s*XLEN +: XLEN];
                    r.late = shadow_q[s].is_load && (s < LOAD_RDY_STAGE);
                end
            end
        end
        return r;
    endfunction

    // Operand resolution and load-use stall request.
    always_comb begin
        fwd_a      = lookup(uses_rs1, rs1_de, rs1_rf);
        fwd_b      = lookup(uses_rs2, rs2_de, rs2_rf);
        fwd_sel_a  = fwd_a.sel;
        fwd_sel_b  = fwd_b.sel;
        data_a_mgr = fwd_a.data;
        data_b_mgr = fwd_b.data;
        stall      = valid_de && !flush && (fwd_a.late || fwd_b.late);
    end

    // Next shadow contents and saturating stall counter.
    always_comb begin
        shadow_d[0].valid   = valid_de && !stall && !flush && writes_rd && (rd_de != 5'd0);
        shadow_d[0].rd      = rd_de;
        shadow_d[0].is_load = is_load_de;
        for (int unsigned s = 1; s < NSTAGE; s++) begin
            shadow_d[s] = shadow_q[s-1];
        end
        cnt_d = cnt_q;
        if (stall && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Shadow shift register and counter; both frozen while hold is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned s = 0; s < NSTAGE; s++) begin
                shadow_q[s] <= '0;
            end
            cnt_q <= '0;
        end else if (!hold) begin
            for (int unsigned s = 0; s < NSTAGE; s++) begin
                shadow_q[s] <= shadow_d[s];
            end
            cnt_q <= cnt_d;
        end
    end

    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Self-checking bench for fwd_hazard_scoreboard: cycle-by-cycle vector table,
// a mid-stall asynchronous reset sequence and a stall-counter saturation run.
module tb_fwd_hazard_scoreboard;

    localparam logic [31:0] RF1 = 32'h1111_1111;
    localparam logic [31:0] RF2 = 32'h2222_2222;
    localparam logic [31:0] D0  = 32'hD000_00D0;
    localparam logic [31:0] D1  = 32'hD111_11D1;
    localparam logic [31:0] D2  = 32'hD222_22D2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_de;
    logic        valid_de, hold, flush;
    logic [31:0] rs1_rf, rs2_rf;
    logic [95:0] stage_data;
    logic [31:0] data_a_mgr, data_b_mgr;
    logic [1:0]  fwd_sel_a, fwd_sel_b;
    logic        stall;
    logic [3:0]  stall_cnt;

    fwd_hazard_scoreboard #(
        .XLEN          (32),
        .NSTAGE        (3),
        .LOAD_RDY_STAGE(1),
        .CNT_W         (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .instr_de  (instr_de),
        .valid_de  (valid_de),
        .hold      (hold),
        .flush     (flush),
        .rs1_rf    (rs1_rf),
        .rs2_rf    (rs2_rf),
        .stage_data(stage_data),
        .data_a_mgr(data_a_mgr),
        .data_b_mgr(data_b_mgr),
        .fwd_sel_a (fwd_sel_a),
        .fwd_sel_b (fwd_sel_b),
        .stall     (stall),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        valid, hold, flush;
        logic [31:0] sd0, sd1, sd2;
        logic [1:0]  sela, selb;
        logic [31:0] da, db;
        logic        stall;
        logic [3:0]  cnt;
        logic        care;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   vec_id = 0;

    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, op};
    endfunction
    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [11:0] imm);
        return enc_i(7'b0010011, rd, rs1, imm);
    endfunction
    function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1);
        return enc_i(7'b0000011, rd, rs1, 12'd0);
    endfunction
    function automatic logic [31:0] add(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] sw(input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b010, 5'b0, 7'b0100011};
    endfunction
    function automatic logic [31:0] beq(input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, 5'b0, 7'b1100011};
    endfunction

    function automatic vec_t mk(input logic [31:0] instr, input logic valid, input logic hld,
                                input logic fl, input logic [31:0] sd0, input logic [31:0] sd1,
                                input logic [31:0] sd2, input logic [1:0] sela,
                                input logic [1:0] selb, input logic [31:0] da,
                                input logic [31:0] db, input logic stl, input logic [3:0] cnt,
                                input logic care);
        vec_t v;
        v.instr = instr; v.valid = valid; v.hold = hld; v.flush = fl;
        v.sd0 = sd0; v.sd1 = sd1; v.sd2 = sd2;
        v.sela = sela; v.selb = selb; v.da = da; v.db = db;
        v.stall = stl; v.cnt = cnt; v.care = care;
        return v;
    endfunction

    task automatic chk(input string what, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec%0d: got %0h expected %0h", what, vec_id, act, exp);
        end
    endtask

    task automatic check_out();
        vec_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard vec%0d: got empty queue expected one record", vec_id);
        end else begin
            e = exp_q.pop_front();
            chk("stall", {31'b0, stall}, {31'b0, e.stall});
            chk("stall_cnt", {28'b0, stall_cnt}, {28'b0, e.cnt});
            if (e.care) begin
                chk("fwd_sel_a", {30'b0, fwd_sel_a}, {30'b0, e.sela});
                chk("fwd_sel_b", {30'b0, fwd_sel_b}, {30'b0, e.selb});
                chk("data_a", data_a_mgr, e.da);
                chk("data_b", data_b_mgr, e.db);
            end
        end
        vec_id++;
    endtask

    task automatic step(input vec_t v);
        @(negedge clk);
        instr_de   = v.instr;
        valid_de   = v.valid;
        hold       = v.hold;
        flush      = v.flush;
        stage_data = {v.sd2, v.sd1, v.sd0};
        exp_q.push_back(v);
        #1;
        check_out();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_cnt;

        // Cycle-by-cycle expectations; comments give shadow {s0,s1,s2} before the cycle.
        tbl.push_back(mk(add(0,5,5),   1,0,0, D0,D1,D2, 0,0, RF1,RF2, 0,0,1)); // empty
        tbl.push_back(mk(addi(5,0,7),  1,0,0, D0,D1,D2, 0,0, RF1,RF2, 0,0,1));
        tbl.push_back(mk(add(6,5,5),   1,0,0, 7, D1,D2, 1,1, 7,  7,   0,0,1)); // x5,-,-
        tbl.push_back(mk(lw(5,1),      1,0,0, D0,D1,D2, 0,0, RF1,RF2, 0,0,1)); // x6,x5,-
        tbl.push_back(mk(add(6,5,2),   1,0,0, D0,D1,D2, 0,0, 0,  0,   1,0,0)); // x5L,x6,x5
        tbl.push_back(mk(add(6,5,2),   1,0,0, D0,D1,D2, 2,0, D1, RF2, 0,1,1)); // -,x5L,x6
        tbl.push_back(mk(addi(0,0,1),  1,0,0, D0,D1,D2, 0,0, RF1,RF2, 0,1,1));
        tbl.push_back(mk(add(6,0,0),   1,0,0, D0,D1,D2, 0,0, RF1,RF2, 0,1,1)); // -,x6,-
        tbl.push_back(mk(addi(5,0,3),  1,0,0, D0,D1,D2, 0,0, RF1,RF2, 0,1,1));
        tbl.push_back(mk(addi(8,0,0),  1,0,0, D0,D1,D2, 0,0, RF1,RF2, 0,1,1));
        tbl.push_back(mk(addi(5,0,9),  1,0,0, D0,D1,D2, 0,0, RF1,RF2, 0,1,1));
        tbl.push_back(mk(add(7,5,5),   1,0,0, 9, D1,3,  1,1, 9,  9,   0,1,1)); // x5,x8,x5
        tbl.push_back(mk(sw(7,5),      1,0,0, D0,D1,D2, 1,2, D0, D1,  0,1,1)); // x7,x5,x8
        tbl.push_back(mk(addi(5,0,1),  1,0,1, D0,D1,D2, 0,0, RF1,RF2, 0,1,1)); // flushed
        tbl.push_back(mk(add(9,5,5),   1,0,0, D0,D1,D2, 0,0, RF1,RF2, 0,1,1)); // -,-,x7
        tbl.push_back(mk(lw(10,0),     1,0,0, D0,D1,D2, 0,0, RF1,RF2, 0,1,1));
        tbl.push_back(mk(add(11,10,9), 1,1,0, D0,D1,D2, 0,0, 0,  0,   1,1,0)); // held
        tbl.push_back(mk(add(11,10,9), 1,1,0, D0,D1,D2, 0,0, 0,  0,   1,1,0));
        tbl.push_back(mk(add(11,10,9), 1,1,0, D0,D1,D2, 0,0, 0,  0,   1,1,0));
        tbl.push_back(mk(add(11,10,9), 1,0,0, D0,D1,D2, 0,0, 0,  0,   1,1,0));
        tbl.push_back(mk(add(11,10,9), 1,0,0, D0,D1,D2, 2,3, D1, D2,  0,2,1)); // -,x10L,x9
        tbl.push_back(mk(lw(11,2),     1,0,0, D0,D1,D2, 0,0, RF1,RF2, 0,2,1)); // x11,-,x10L
        tbl.push_back(mk(add(12,3,11), 1,0,0, D0,D1,D2, 0,0, 0,  0,   1,2,0)); // x11L,x11,-
        tbl.push_back(mk(add(12,3,11), 1,0,0, D0,D1,D2, 0,2, RF1,D1,  0,3,1)); // -,x11L,x11
        tbl.push_back(mk(beq(11,12),   1,0,0, D0,D1,D2, 3,1, D2, D0,  0,3,1)); // x12,-,x11L
        tbl.push_back(mk({7'b0,5'd12,5'd12,3'b0,5'd13,7'b0110111},
                                       1,0,0, D0,D1,D2, 0,0, RF1,RF2, 0,3,1)); // LUI, -,x12,-
        tbl.push_back(mk(lw(14,0),     1,0,0, D0,D1,D2, 0,0, RF1,RF2, 0,3,1));
        tbl.push_back(mk(add(15,14,13),0,0,0, D0,D1,D2, 1,2, D0, D1,  0,3,1)); // x14L,x13,-
        tbl.push_back(mk(lw(20,0),     1,0,0, D0,D1,D2, 0,0, RF1,RF2, 0,3,1));
        tbl.push_back(mk(addi(21,0,0), 1,0,0, D0,D1,D2, 0,0, RF1,RF2, 0,3,1));
        tbl.push_back(mk(lw(22,0),     1,0,0, D0,D1,D2, 0,0, RF1,RF2, 0,3,1));
        tbl.push_back(mk(add(23,22,21),1,0,0, D0,D1,D2, 0,0, 0,  0,   1,3,0)); // x22L,x21,x20L

        rst        = 1'b1;
        instr_de   = '0;
        valid_de   = 1'b0;
        hold       = 1'b0;
        flush      = 1'b0;
        rs1_rf     = RF1;
        rs2_rf     = RF2;
        stage_data = {D2, D1, D0};
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i]);
        end

        // Asynchronous reset while the last vector is stalling with three valid entries.
        #1;
        rst = 1'b1;
        #1;
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_stall_cnt", {28'b0, stall_cnt}, 32'd0);
        chk("rst_fwd_sel_a", {30'b0, fwd_sel_a}, 32'd0);
        chk("rst_fwd_sel_b", {30'b0, fwd_sel_b}, 32'd0);
        chk("rst_data_a", data_a_mgr, RF1);
        @(negedge clk);
        rst = 1'b0;
        step(mk(add(23,22,21), 1,0,0, D0,D1,D2, 0,0, RF1,RF2, 0,0,1));

        // Repeated load-use pairs drive the 4-bit counter into saturation.
        exp_cnt = '0;
        for (int i = 0; i < 18; i++) begin
            step(mk(lw(20,0),      1,0,0, D0,D1,D2, 0,0, RF1,RF2, 0,exp_cnt,1));
            step(mk(add(21,20,20), 1,0,0, D0,D1,D2, 0,0, 0,  0,   1,exp_cnt,0));
            if (exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
            step(mk(add(21,20,20), 1,0,0, D0,D1,D2, 2,2, D1, D1,  0,exp_cnt,1));
        end
        chk("sat_cnt", {28'b0, stall_cnt}, 32'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
